// File: rtl/uart_alu_pkg.sv
// ----------------------------------------------------------------------------
// uart_alu_pkg
// Shared types and constants for the UART ALU command responder:
//   opcode_e  - request opcodes understood by the ALU
//   state_e   - responder FSM states
//   STATUS_*  - response status byte values
//   status_of - maps the ALU opcode-valid flag to a status byte
// ----------------------------------------------------------------------------
package uart_alu_pkg;

    typedef enum logic [7:0] {
        OP_ADD = 8'h00,
        OP_SUB = 8'h01,
        OP_AND = 8'h02,
        OP_OR  = 8'h03,
        OP_XOR = 8'h04,
        OP_MUL = 8'h05
    } opcode_e;

    localparam logic [7:0] STATUS_OK     = 8'h00;
    localparam logic [7:0] STATUS_BAD_OP = 8'h01;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RX_A = 3'd1,
        RX_B = 3'd2,
        EXEC = 3'd3,
        TX   = 3'd4
    } state_e;

    function automatic logic [7:0] status_of(input logic opcode_valid);
        return opcode_valid ? STATUS_OK : STATUS_BAD_OP;
    endfunction

endpackage

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational W-bit ALU. Arithmetic wraps modulo 2^W; MUL keeps the
// low W bits of the product. Unknown opcodes give result 0 and flag invalid.
// Ports:
//   i_opcode       - request opcode byte
//   i_a, i_b       - operands
//   o_result       - operation result
//   o_opcode_valid - 1 when i_opcode is one of opcode_e
// ----------------------------------------------------------------------------
module alu_core
    import uart_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [7:0]   i_opcode,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_result,
    output logic         o_opcode_valid
);

    // Opcode decode and operation select.
    always_comb begin
        o_result       = {W{1'b0}};
        o_opcode_valid = 1'b0;
        case (i_opcode)
            OP_ADD: begin o_result = i_a + i_b; o_opcode_valid = 1'b1; end
            OP_SUB: begin o_result = i_a - i_b; o_opcode_valid = 1'b1; end
            OP_AND: begin o_result = i_a & i_b; o_opcode_valid = 1'b1; end
            OP_OR:  begin o_result = i_a | i_b; o_opcode_valid = 1'b1; end
            OP_XOR: begin o_result = i_a ^ i_b; o_opcode_valid = 1'b1; end
            OP_MUL: begin o_result = i_a * i_b; o_opcode_valid = 1'b1; end
            default: begin
                o_result       = {W{1'b0}};
                o_opcode_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uart_alu_responder.sv
// ----------------------------------------------------------------------------
// uart_alu_responder
// Sits between uart_rx (AXI-stream master) and uart_tx (AXI-stream slave).
// Collects a request frame {OPCODE, A[LSB first], B[LSB first]}, runs one ALU
// operation and returns {STATUS, RESULT[LSB first]}. A partial request that
// stalls longer than TIMEOUT_CYCLES between bytes is dropped silently apart
// from a one-cycle timeout_o pulse. Only DATA_WIDTH = 8 is supported.
// Ports:
//   clk_i, rst_ni            - clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready - request byte stream in
//   m_axis_tdata/tvalid/tready - response byte stream out
//   busy_o                   - high whenever the FSM is not in IDLE
//   timeout_o                - one-cycle pulse when a partial frame is dropped
// ----------------------------------------------------------------------------
module uart_alu_responder
    import uart_alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int OPERAND_BYTES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int W      = 8 * OPERAND_BYTES;
    localparam int IDX_W  = $clog2(OPERAND_BYTES + 1);
    localparam int RESP_W = DATA_WIDTH * (OPERAND_BYTES + 1);
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);

    localparam logic [TO_W-1:0]  TO_LAST   = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1)
                                                                  : {TO_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(OPERAND_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_TX   = IDX_W'(OPERAND_BYTES);

    state_e                  r_state;
    logic [7:0]              r_opcode;
    logic [W-1:0]            r_a;
    logic [W-1:0]            r_b;
    logic [IDX_W-1:0]        r_byte_cnt;
    logic [IDX_W-1:0]        r_tx_idx;
    logic [TO_W-1:0]         r_idle_cnt;
    logic [RESP_W-1:0]       r_resp;     // {RESULT, STATUS}: byte i is tx index i
    logic                    r_s_tready;
    logic                    r_m_tvalid;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic                    r_busy;
    logic                    r_timeout;

    logic                    w_s_acc;
    logic                    w_m_acc;
    logic                    w_to_hit;
    logic [IDX_W-1:0]        w_tx_idx_nxt;
    logic [W-1:0]            w_result;
    logic                    w_op_valid;

    assign w_s_acc      = s_axis_tvalid && r_s_tready;
    assign w_m_acc      = r_m_tvalid && m_axis_tready;
    assign w_to_hit     = TO_EN && (r_idle_cnt == TO_LAST);
    assign w_tx_idx_nxt = r_tx_idx + IDX_W'(1);

    alu_core #(
        .W (W)
    ) u_alu (
        .i_opcode       (r_opcode),
        .i_a            (r_a),
        .i_b            (r_b),
        .o_result       (w_result),
        .o_opcode_valid (w_op_valid)
    );

    // Responder FSM with all counters, operand/result registers and outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_opcode   <= 8'h00;
            r_a        <= {W{1'b0}};
            r_b        <= {W{1'b0}};
            r_byte_cnt <= {IDX_W{1'b0}};
            r_tx_idx   <= {IDX_W{1'b0}};
            r_idle_cnt <= {TO_W{1'b0}};
            r_resp     <= {RESP_W{1'b0}};
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= {DATA_WIDTH{1'b0}};
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_s_tready <= 1'b1;
                    r_idle_cnt <= {TO_W{1'b0}};
                    if (w_s_acc) begin
                        r_opcode   <= s_axis_tdata;
                        r_a        <= {W{1'b0}};
                        r_b        <= {W{1'b0}};
                        r_byte_cnt <= {IDX_W{1'b0}};
                        r_busy     <= 1'b1;
                        r_state    <= RX_A;
                    end else begin
                        r_busy     <= 1'b0;
                    end
                end

                RX_A, RX_B: begin
                    if (w_s_acc) begin
                        // An accept in the timeout cycle wins over the timeout.
                        r_idle_cnt <= {TO_W{1'b0}};
                        if (r_state == RX_A) begin
                            r_a[{r_byte_cnt, 3'b000} +: 8] <= s_axis_tdata;
                        end else begin
                            r_b[{r_byte_cnt, 3'b000} +: 8] <= s_axis_tdata;
                        end
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_byte_cnt <= {IDX_W{1'b0}};
                            if (r_state == RX_A) begin
                                r_state    <= RX_B;
                            end else begin
                                r_state    <= EXEC;
                                r_s_tready <= 1'b0;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + IDX_W'(1);
                        end
                    end else if (w_to_hit) begin
                        // Drop the partial frame; tready stays high for IDLE.
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_byte_cnt <= {IDX_W{1'b0}};
                        r_idle_cnt <= {TO_W{1'b0}};
                    end else if (TO_EN) begin
                        r_idle_cnt <= r_idle_cnt + TO_W'(1);
                    end else begin
                        r_idle_cnt <= {TO_W{1'b0}};
                    end
                end

                EXEC: begin
                    r_resp   <= {w_result, status_of(w_op_valid)};
                    r_tx_idx <= {IDX_W{1'b0}};
                    r_state  <= TX;
                end

                TX: begin
                    if (!r_m_tvalid) begin
                        // First TX cycle: present the status byte.
                        r_m_tdata  <= r_resp[{r_tx_idx, 3'b000} +: 8];
                        r_m_tvalid <= 1'b1;
                    end else if (w_m_acc) begin
                        if (r_tx_idx == LAST_TX) begin
                            r_m_tvalid <= 1'b0;
                            r_s_tready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_tx_idx   <= w_tx_idx_nxt;
                            r_m_tdata  <= r_resp[{w_tx_idx_nxt, 3'b000} +: 8];
                        end
                    end else begin
                        // Backpressure: hold the presented byte.
                        r_m_tdata  <= r_m_tdata;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_s_tready <= 1'b0;
                    r_m_tvalid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign busy_o        = r_busy;
    assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_uart_alu_responder.sv
// ----------------------------------------------------------------------------
// tb_uart_alu_responder
// Scoreboard bench: each request frame pushes its expected response bytes to
// a queue; every response handshake pops and compares one byte.
// ----------------------------------------------------------------------------
module tb_uart_alu_responder;

    localparam int TO = 50;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic       busy_o;
    logic       timeout_o;

    int         errs = 0;
    int         checks = 0;
    int         to_pulses = 0;
    logic [7:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    uart_alu_responder #(
        .DATA_WIDTH     (8),
        .OPERAND_BYTES  (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    // Count timeout pulses.
    always @(negedge clk_i) begin
        if (timeout_o) to_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_status(input logic [7:0] op);
        return (op <= 8'h05) ? 8'h00 : 8'h01;
    endfunction

    function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (op)
            8'h00:   return a + b;
            8'h01:   return a - b;
            8'h02:   return a & b;
            8'h03:   return a | b;
            8'h04:   return a ^ b;
            8'h05:   return p[31:0];
            default: return 32'h0;
        endcase
    endfunction

    // Drive one request byte; returns at posedge+1 after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!s_axis_tready && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!s_axis_tready) check_eq("s_tready_wait", 32'd0, 32'd1);
        @(posedge clk_i);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        int lat;
        res = ref_result(op, a, b);
        exp_q.push_back(ref_status(op));
        for (int i = 0; i < 4; i++) exp_q.push_back(res[8*i +: 8]);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
        lat = 0;
        while (!m_axis_tvalid && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check_eq("first_byte_latency", lat, 32'd2);
    endtask

    // Collect n_bytes response bytes; stall m_axis_tready at byte stall_at.
    task automatic recv_resp(input int n_bytes, input int stall_at);
        int n;
        logic [7:0] held;
        logic [7:0] exp;
        for (int i = 0; i < n_bytes; i++) begin
            if (i == stall_at) begin
                m_axis_tready = 1'b0;
                @(negedge clk_i);
                held = m_axis_tdata;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk_i);
                    check_eq("stall_tvalid", m_axis_tvalid, 32'd1);
                    check_eq("stall_tdata", m_axis_tdata, held);
                    check_eq("stall_s_tready", s_axis_tready, 32'd0);
                end
                @(posedge clk_i);
                #1;
            end
            m_axis_tready = 1'b1;
            n = 0;
            @(negedge clk_i);
            while (!m_axis_tvalid && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            if (!m_axis_tvalid) check_eq("m_tvalid_wait", 32'd0, 32'd1);
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", m_axis_tdata, 32'hxx);
            end else begin
                exp = exp_q.pop_front();
                check_eq("resp_byte", m_axis_tdata, exp);
            end
            @(posedge clk_i);
            #1;
        end
        m_axis_tready = 1'b0;
        if (n_bytes == 5) begin
            check_eq("tvalid_after_frame", m_axis_tvalid, 32'd0);
            check_eq("busy_after_frame", busy_o, 32'd0);
            check_eq("s_tready_after_frame", s_axis_tready, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [7:0]  rop;
        int          to_before;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_s_tready", s_axis_tready, 32'd0);
        check_eq("rst_m_tvalid", m_axis_tvalid, 32'd0);
        check_eq("rst_m_tdata", m_axis_tdata, 32'd0);
        check_eq("rst_busy", busy_o, 32'd0);
        check_eq("rst_timeout", timeout_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("post_rst_s_tready", s_axis_tready, 32'd1);

        // Directed operations
        send_frame(8'h00, 32'h0000_0005, 32'h0000_0003); recv_resp(5, -1);
        check_eq("add_no_timeout", to_pulses, 32'd0);
        send_frame(8'h01, 32'h0000_0000, 32'h0000_0001); recv_resp(5, -1);
        send_frame(8'h05, 32'h0001_0000, 32'h0001_0000); recv_resp(5, -1);
        send_frame(8'h02, 32'hF0F0_1234, 32'h0FF0_FF00); recv_resp(5, -1);
        send_frame(8'h03, 32'h8000_0001, 32'h0100_0010); recv_resp(5, -1);
        send_frame(8'h7F, 32'h1234_5678, 32'h9ABC_DEF0); recv_resp(5, -1);
        send_frame(8'h00, 32'hFFFF_FFFF, 32'h0000_0002); recv_resp(5, -1);

        // Backpressure mid-response
        send_frame(8'h04, 32'hDEAD_BEEF, 32'h1357_9BDF); recv_resp(5, 2);

        // Random frames, including one invalid opcode value
        for (int f = 0; f < 6; f++) begin
            rop = 8'($urandom_range(0, 6));
            ra  = $urandom;
            rb  = $urandom;
            send_frame(rop, ra, rb);
            recv_resp(5, (f == 3) ? 4 : -1);
        end

        // Timeout on a partial frame
        to_before = to_pulses;
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TO - 1) @(posedge clk_i);
        #1;
        check_eq("to_not_early_busy", busy_o, 32'd1);
        check_eq("to_not_early_pulse", to_pulses - to_before, 32'd0);
        @(posedge clk_i);
        #1;
        check_eq("to_pulse", timeout_o, 32'd1);
        check_eq("to_busy", busy_o, 32'd0);
        @(posedge clk_i);
        #1;
        check_eq("to_pulse_width", timeout_o, 32'd0);
        check_eq("to_no_response", m_axis_tvalid, 32'd0);
        repeat (5) @(posedge clk_i);
        #1;
        check_eq("to_pulse_count", to_pulses - to_before, 32'd1);
        send_frame(8'h00, 32'h0000_0100, 32'h0000_0023); recv_resp(5, -1);

        // Reset in the middle of a response
        send_frame(8'h00, 32'h0102_0304, 32'h1010_1010);
        recv_resp(2, -1);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check_eq("midrst_tvalid", m_axis_tvalid, 32'd0);
        check_eq("midrst_busy", busy_o, 32'd0);
        exp_q.delete();
        rst_ni = 1'b1;
        m_axis_tready = 1'b1;
        repeat (5) begin
            @(posedge clk_i);
            #1;
            check_eq("midrst_no_more_bytes", m_axis_tvalid, 32'd0);
        end
        m_axis_tready = 1'b0;
        check_eq("midrst_s_tready", s_axis_tready, 32'd1);
        send_frame(8'h04, 32'hFF00_FF00, 32'h0F0F_0F0F); recv_resp(5, -1);

        check_eq("sb_empty", exp_q.size(), 32'd0);
        check_eq("total_timeouts", to_pulses, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
